// File: rtl/pl_to_ps_arb_pkg.sv
// Shared types and constants for the PL-to-PS FIFO arbiter.
package pl_to_ps_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int unsigned beat_cnt_width_gp = 32;

endpackage

// File: rtl/pl_to_ps_rr_select.sv
// Rotating-priority selector: first asserted request at or above rr_ptr_i, wrapping.
module pl_to_ps_rr_select #(
    parameter  int unsigned num_req_p = 4,
    localparam int unsigned idx_w_lp  = $clog2(num_req_p)
) (
    input  logic [num_req_p-1:0] req_i,
    input  logic [idx_w_lp-1:0]  rr_ptr_i,
    output logic [idx_w_lp-1:0]  sel_o,
    output logic                 any_v_o
);

    logic [idx_w_lp-1:0] idx;

    always_comb begin
        sel_o   = '0;
        any_v_o = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < num_req_p; k++) begin
            idx = idx_w_lp'((32'(rr_ptr_i) + k) % num_req_p);
            if (!any_v_o && req_i[idx]) begin
                any_v_o = 1'b1;
                sel_o   = idx;
            end
        end
    end

endmodule

// File: rtl/pl_to_ps_fifo_arbiter.sv
// Round-robin arbiter with burst locking feeding the PL-to-PS FIFO; data passes through
// combinationally, and per-requester saturating beat counters are kept for the PS.
module pl_to_ps_fifo_arbiter
    import pl_to_ps_arb_pkg::*;
#(
    parameter  int unsigned num_req_p     = 4,
    parameter  int unsigned width_p       = 32,
    parameter  int unsigned burst_width_p = 4,
    localparam int unsigned idx_w_lp      = $clog2(num_req_p)
) (
    input  logic                                          clk_i,
    input  logic                                          reset_i,
    input  logic [num_req_p-1:0][width_p-1:0]             req_data_i,
    input  logic [num_req_p-1:0]                          req_v_i,
    output logic [num_req_p-1:0]                          req_yumi_o,
    input  logic [burst_width_p-1:0]                      burst_len_i,
    output logic [width_p-1:0]                            data_o,
    output logic                                          v_o,
    input  logic                                          ready_i,
    output logic [idx_w_lp-1:0]                           grant_id_o,
    input  logic                                          cnt_clear_i,
    output logic [num_req_p-1:0][beat_cnt_width_gp-1:0]   beat_cnt_o
);

    arb_state_e                                      state_q;
    logic [idx_w_lp-1:0]                             rr_ptr_q;
    logic [idx_w_lp-1:0]                             owner_q;
    logic [burst_width_p-1:0]                        remaining_q;
    logic [num_req_p-1:0][beat_cnt_width_gp-1:0]     beat_cnt_q;

    logic [idx_w_lp-1:0]      sel;
    logic                     any_v;
    logic                     xfer;
    logic [burst_width_p-1:0] eff_len;

    function automatic logic [idx_w_lp-1:0] wrap_inc(input logic [idx_w_lp-1:0] i);
        return (i == idx_w_lp'(num_req_p - 1)) ? '0 : i + idx_w_lp'(1);
    endfunction

    pl_to_ps_rr_select #(
        .num_req_p (num_req_p)
    ) u_rr_select (
        .req_i    (req_v_i),
        .rr_ptr_i (rr_ptr_q),
        .sel_o    (sel),
        .any_v_o  (any_v)
    );

    assign eff_len = (burst_len_i == '0) ? burst_width_p'(1) : burst_len_i;

    // Zero-latency output mux: lock owner when LOCKED, else the rotating selection.
    always_comb begin
        v_o        = 1'b0;
        grant_id_o = '0;
        data_o     = '0;
        if (state_q == LOCKED) begin
            v_o        = req_v_i[owner_q];
            grant_id_o = owner_q;
            data_o     = req_data_i[owner_q];
        end else if (any_v) begin
            v_o        = 1'b1;
            grant_id_o = sel;
            data_o     = req_data_i[sel];
        end
        if (reset_i) begin
            v_o = 1'b0;
        end
    end

    assign xfer       = v_o & ready_i;
    assign req_yumi_o = xfer ? (num_req_p'(1) << grant_id_o) : '0;
    assign beat_cnt_o = beat_cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            remaining_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        if (eff_len == burst_width_p'(1)) begin
                            rr_ptr_q <= wrap_inc(sel);
                        end else begin
                            state_q     <= LOCKED;
                            owner_q     <= sel;
                            remaining_q <= eff_len - burst_width_p'(1);
                        end
                    end
                end
                LOCKED: begin
                    // Owner dropping valid releases the lock without a beat.
                    if (!req_v_i[owner_q]) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= wrap_inc(owner_q);
                    end else if (xfer) begin
                        remaining_q <= remaining_q - burst_width_p'(1);
                        if (remaining_q == burst_width_p'(1)) begin
                            state_q  <= IDLE;
                            rr_ptr_q <= wrap_inc(owner_q);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Saturating beat counters; clear wins over a same-cycle beat.
    always_ff @(posedge clk_i) begin
        if (reset_i || cnt_clear_i) begin
            beat_cnt_q <= '0;
        end else if (xfer && (beat_cnt_q[grant_id_o] != '1)) begin
            beat_cnt_q[grant_id_o] <= beat_cnt_q[grant_id_o] + beat_cnt_width_gp'(1);
        end
    end

endmodule

// File: tb/tb_pl_to_ps_fifo_arbiter.sv
// Scoreboard bench: driver pushes reference-model expectations, monitor pops and compares.
module tb_pl_to_ps_fifo_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 32;
    localparam int unsigned BW = 4;

    logic                   clk = 1'b0;
    logic                   reset_i;
    logic [N-1:0][W-1:0]    req_data_i;
    logic [N-1:0]           req_v_i;
    logic [N-1:0]           req_yumi_o;
    logic [BW-1:0]          burst_len_i;
    logic [W-1:0]           data_o;
    logic                   v_o;
    logic                   ready_i;
    logic [1:0]             grant_id_o;
    logic                   cnt_clear_i;
    logic [N-1:0][31:0]     beat_cnt_o;

    always #5 clk = ~clk;

    pl_to_ps_fifo_arbiter #(
        .num_req_p     (N),
        .width_p       (W),
        .burst_width_p (BW)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .req_data_i  (req_data_i),
        .req_v_i     (req_v_i),
        .req_yumi_o  (req_yumi_o),
        .burst_len_i (burst_len_i),
        .data_o      (data_o),
        .v_o         (v_o),
        .ready_i     (ready_i),
        .grant_id_o  (grant_id_o),
        .cnt_clear_i (cnt_clear_i),
        .beat_cnt_o  (beat_cnt_o)
    );

    typedef struct packed {
        logic               chk_cnt;
        logic               rst;
        logic               v;
        logic [1:0]         grant;
        logic [W-1:0]       data;
        logic [N-1:0]       yumi;
        logic [N-1:0][31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: lock owner and beats left, next-priority index, beat tallies.
    bit          m_locked = 1'b0;
    int          m_owner  = 0;
    int          m_left   = 0;
    int          m_ptr    = 0;
    logic [31:0] m_cnt[N];
    bit          m_known  = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic [N-1:0] v, input logic rdy, input logic [BW-1:0] bl,
                        input logic clr, input logic rst, input bit preset);
        exp_t e;
        int   g;
        bit   mv;
        bit   xfer;
        int   blen;
        @(negedge clk);
        if (preset) begin
            force dut.beat_cnt_q = {N{32'hFFFF_FFFE}};
            release dut.beat_cnt_q;
            for (int i = 0; i < N; i++) m_cnt[i] = 32'hFFFF_FFFE;
        end
        reset_i     = rst;
        req_v_i     = v;
        ready_i     = rdy;
        burst_len_i = bl;
        cnt_clear_i = clr;
        for (int i = 0; i < N; i++) req_data_i[i] = $urandom;
        #1;
        e = '0;
        g = 0;
        mv = 1'b0;
        if (!rst) begin
            if (m_locked) begin
                g  = m_owner;
                mv = v[m_owner];
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (!mv && v[(m_ptr + k) % N]) begin
                        mv = 1'b1;
                        g  = (m_ptr + k) % N;
                    end
                end
            end
        end
        xfer      = mv && rdy;
        e.chk_cnt = m_known;
        e.rst     = rst;
        e.v       = mv;
        e.grant   = 2'(g);
        e.data    = (m_locked || mv) ? req_data_i[g] : '0;
        e.yumi    = xfer ? (4'b0001 << g) : 4'b0000;
        for (int i = 0; i < N; i++) e.cnt[i] = m_cnt[i];
        q.push_back(e);

        if (rst) begin
            m_locked = 1'b0;
            m_owner  = 0;
            m_left   = 0;
            m_ptr    = 0;
            m_known  = 1'b1;
            for (int i = 0; i < N; i++) m_cnt[i] = '0;
        end else begin
            if (clr) begin
                for (int i = 0; i < N; i++) m_cnt[i] = '0;
            end else if (xfer && m_cnt[g] != 32'hFFFF_FFFF) begin
                m_cnt[g] = m_cnt[g] + 1;
            end
            blen = (bl == 0) ? 1 : int'(bl);
            if (m_locked) begin
                if (!v[m_owner]) begin
                    m_locked = 1'b0;
                    m_ptr    = (m_owner + 1) % N;
                end else if (xfer) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_locked = 1'b0;
                        m_ptr    = (m_owner + 1) % N;
                    end
                end
            end else if (xfer) begin
                if (blen == 1) begin
                    m_ptr = (g + 1) % N;
                end else begin
                    m_locked = 1'b1;
                    m_owner  = g;
                    m_left   = blen - 1;
                end
            end
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("v_o", 128'(v_o), 128'(e.v));
                chk("req_yumi_o", 128'(req_yumi_o), 128'(e.yumi));
                if (!e.rst) begin
                    chk("grant_id_o", 128'(grant_id_o), 128'(e.grant));
                    chk("data_o", 128'(data_o), 128'(e.data));
                end
                if (e.chk_cnt) begin
                    chk("beat_cnt_o", 128'(beat_cnt_o), 128'(e.cnt));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) m_cnt[i] = '0;
        reset_i     = 1'b1;
        req_v_i     = '0;
        ready_i     = 1'b0;
        burst_len_i = '0;
        cnt_clear_i = 1'b0;
        req_data_i  = '0;

        repeat (2) step(4'b1111, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0);
        // Single-beat round robin across all requesters.
        repeat (5) step(4'b1111, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        // Burst of 3: lock holds off the other requesters.
        repeat (6) step(4'b1111, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
        // Burst of 4, owner 2 drops valid after two beats.
        repeat (2) step(4'b0100, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
        // Stall of 5 cycles mid-burst, burst length changed during the lock.
        step(4'b1000, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        repeat (5) step(4'b1111, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0);
        repeat (2) step(4'b1111, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        // Counter saturation, then clear on a transfer cycle.
        step(4'b0000, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
        repeat (3) step(4'b0001, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        step(4'b0001, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        // Reset mid-burst with two beats left.
        step(4'b0010, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        step(4'b1111, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0);
        repeat (2) step(4'b1111, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(N'($urandom), ($urandom_range(0, 3) != 0), BW'($urandom_range(0, 5)),
                 ($urandom_range(0, 40) == 0), ($urandom_range(0, 150) == 0), 1'b0);
        end

        #5;
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pl_to_ps_fifo_arbiter.md
PL_TO_PS_FIFO_ARBITER -- requirements
Module: pl_to_ps_fifo_arbiter

Interface
REQ-001 Parameter num_req_p, default 4: number of requesters; SHALL be 2..16.
REQ-002 Parameter width_p, default 32: data width, matching the GP0 AXI data width.
REQ-003 Parameter burst_width_p, default 4: width of burst_len_i.
REQ-004 clk_i  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset_i  in  1  reset; synchronous, active-high.
REQ-006 req_data_i  in  num_req_p x width_p  per-requester data.
REQ-007 req_v_i  in  num_req_p  per-requester valid.
REQ-008 req_yumi_o  out  num_req_p  per-requester dequeue strobe; at most one bit SHALL be set per cycle.
REQ-009 burst_len_i  in  burst_width_p  beats per grant, from a PS-to-PL CSR; 0 SHALL be treated as 1.
REQ-010 data_o  out  width_p  data to the PL-to-PS FIFO.
REQ-011 v_o  out  1  data_o is valid.
REQ-012 ready_i  in  1  PL-to-PS FIFO ready.
REQ-013 grant_id_o  out  clog2(num_req_p)  index of the served requester.
REQ-014 cnt_clear_i  in  1  clears all beat counters.
REQ-015 beat_cnt_o  out  num_req_p x 32  per-requester beat counts, for return to the PS via CSRs.

Function
REQ-016 Transfer definition: a transfer occurs in any cycle where v_o & ready_i; req_yumi_o[grant_id_o] SHALL equal v_o & ready_i, and all other bits SHALL be 0.
REQ-017 FSM states: IDLE and LOCKED.
REQ-018 In IDLE, sel SHALL be the first index i with req_v_i[i]=1, searched from rr_ptr upward with wrap-around.
REQ-019 In IDLE, v_o = |req_v_i, data_o = req_data_i[sel], and grant_id_o = sel, all combinationally (zero latency).
REQ-020 In IDLE, with no requester valid: v_o=0, grant_id_o=0, data_o=0.
REQ-021 IDLE, transfer, and effective burst length 1: stay IDLE; rr_ptr <= (sel+1) mod num_req_p.
REQ-022 IDLE, transfer, and effective burst length >1: go to LOCKED; owner <= sel; remaining <= burst_len-1, with burst_len sampled only at this grant.
REQ-023 In LOCKED, only the owner is served: v_o = req_v_i[owner], data_o = req_data_i[owner], grant_id_o = owner.
REQ-024 In LOCKED, other requesters' valids SHALL be ignored.
REQ-025 LOCKED, transfer: remaining decrements; if remaining was 1, go to IDLE and set rr_ptr <= (owner+1) mod num_req_p.
REQ-026 LOCKED, owner req_v_i=0: the lock SHALL release that cycle (next state IDLE, rr_ptr <= owner+1, no transfer).
REQ-027 LOCKED, owner valid but ready_i=0: state, remaining and owner SHALL hold; v_o and data_o SHALL stay stable.
REQ-028 Changes to burst_len_i during LOCKED SHALL NOT affect the current burst.
REQ-029 Counters: beat_cnt_o[i] SHALL increment on each transfer from requester i and saturate at 32'hFFFF_FFFF.
REQ-030 cnt_clear_i=1 SHALL zero all counters next cycle, taking priority over a same-cycle increment; that beat is not counted.

Reset
REQ-031 reset_i=1 SHALL force: state=IDLE, rr_ptr=0, owner=0, remaining=0, all beat_cnt_o=0.
REQ-032 During reset, req_yumi_o SHALL be all 0 and v_o=0, regardless of inputs.
REQ-033 Reset asserted mid-burst SHALL abandon the burst with no yumi issued; the first post-reset grant SHALL start from requester 0.

Structure
REQ-034 Shared package pl_to_ps_arb_pkg SHALL hold the state enum (IDLE, LOCKED) and the constant beat_cnt_width_gp=32.
REQ-035 One sub-module, pl_to_ps_rr_select: combinational rotating-priority selector (req vector, rr_ptr -> sel, any_v); it SHALL be used by the IDLE path.
REQ-036 All state SHALL be in this module; no internal buffering (data passes through combinationally).

Verification
REQ-037 N=4, burst_len=1, all valid, ready=1: grants 0,1,2,3,0 on consecutive cycles; one yumi per cycle.
REQ-038 burst_len=3, req 1 and 2 valid, ready=1: grants 1,1,1,2,2,2; req 0 and 3 are ignored during the lock.
REQ-039 burst_len=4, owner 2 drops valid after 2 beats: IDLE next cycle, rr_ptr=3; beat_cnt_o[2]=2.
REQ-040 ready_i=0 for 5 cycles mid-burst: v_o, data_o and grant_id_o stable; no yumi; burst completes after ready returns.
REQ-041 beat_cnt_o[0] preloaded near 32'hFFFF_FFFE, 3 beats: value stays 32'hFFFF_FFFF; cnt_clear_i asserted on a transfer cycle gives 0, not 1.
REQ-042 reset_i asserted during LOCKED with remaining=2: post-reset grant starts at requester 0; all counters read 0.
